// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, RV32I opcode constants and the alternate funct7 encoding
package alu_pkg;
    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_XOR   = 6'd2;
    localparam logic [5:0] ALU_OR    = 6'd3;
    localparam logic [5:0] ALU_AND   = 6'd4;
    localparam logic [5:0] ALU_SLL   = 6'd5;
    localparam logic [5:0] ALU_SRL   = 6'd6;
    localparam logic [5:0] ALU_SRA   = 6'd7;
    localparam logic [5:0] ALU_SLT   = 6'd8;
    localparam logic [5:0] ALU_SLTU  = 6'd9;
    localparam logic [5:0] ALU_ADDI  = 6'd10;
    localparam logic [5:0] ALU_XORI  = 6'd11;
    localparam logic [5:0] ALU_ORI   = 6'd12;
    localparam logic [5:0] ALU_ANDI  = 6'd13;
    localparam logic [5:0] ALU_SLLI  = 6'd14;
    localparam logic [5:0] ALU_SRLI  = 6'd15;
    localparam logic [5:0] ALU_SRAI  = 6'd16;
    localparam logic [5:0] ALU_SLTI  = 6'd17;
    localparam logic [5:0] ALU_SLTIU = 6'd18;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: ID/EX bus from the issue stage (master) to the ALU (slave)
interface alu_issue_stage_if #(parameter int XLEN = 32);
    logic            ex_valid;
    logic            ex_ready;
    logic [5:0]      alu_op;
    logic [XLEN-1:0] data_in_1;
    logic [XLEN-1:0] data_in_2;
    logic [4:0]      rd_addr;
    logic            reg_write;
    logic            illegal;
    modport master (output ex_valid, alu_op, data_in_1, data_in_2, rd_addr, reg_write, illegal, input ex_ready);
    modport slave (input ex_valid, alu_op, data_in_1, data_in_2, rd_addr, reg_write, illegal, output ex_ready);
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps OP / OP-IMM encodings to an ALU op code and operand-select flags
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  alu_op,
    output logic        use_imm,
    output logic        is_shift,
    output logic        legal
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       is_op;
    logic       is_imm;
    logic       f7_zero;
    logic       f7_alt;
    logic       unused;
    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_op    = opc == OPC_OP;
    assign is_imm   = opc == OPC_OP_IMM;
    assign f7_zero  = f7 == 7'd0;
    assign f7_alt   = f7 == FUNCT7_ALT;
    assign use_imm  = is_imm;
    assign is_shift = (is_op | is_imm) & (f3 == 3'd1 | f3 == 3'd5);
    assign unused   = ^instr[24:7];
    // funct7 must be zero except where it selects SUB/SRA/SRAI; unsupported encodings yield ALU_ADD
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
        if (is_op) begin
            case (f3)
                3'd0: begin alu_op = f7_alt ? ALU_SUB : ALU_ADD; legal = f7_zero | f7_alt; end
                3'd1: begin alu_op = ALU_SLL;  legal = f7_zero; end
                3'd2: begin alu_op = ALU_SLT;  legal = f7_zero; end
                3'd3: begin alu_op = ALU_SLTU; legal = f7_zero; end
                3'd4: begin alu_op = ALU_XOR;  legal = f7_zero; end
                3'd5: begin alu_op = f7_alt ? ALU_SRA : ALU_SRL; legal = f7_zero | f7_alt; end
                3'd6: begin alu_op = ALU_OR;   legal = f7_zero; end
                default: begin alu_op = ALU_AND; legal = f7_zero; end
            endcase
        end else if (is_imm) begin
            case (f3)
                3'd0: begin alu_op = ALU_ADDI;  legal = 1'b1; end
                3'd1: begin alu_op = ALU_SLLI;  legal = f7_zero; end
                3'd2: begin alu_op = ALU_SLTI;  legal = 1'b1; end
                3'd3: begin alu_op = ALU_SLTIU; legal = 1'b1; end
                3'd4: begin alu_op = ALU_XORI;  legal = 1'b1; end
                3'd5: begin alu_op = f7_alt ? ALU_SRAI : ALU_SRLI; legal = f7_zero | f7_alt; end
                3'd6: begin alu_op = ALU_ORI;   legal = 1'b1; end
                default: begin alu_op = ALU_ANDI; legal = 1'b1; end
            endcase
        end
        if (!legal) alu_op = ALU_ADD;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage feeding the ALU; ALU_ISSUE_ILLEGAL_EN issues unsupported encodings flagged illegal
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    alu_issue_stage_if.master ex
);
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif
    logic [5:0]      dec_op;
    logic            use_imm;
    logic            is_shift;
    logic            legal;
    logic            xfer;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op2;
    alu_op_decode u_dec (
        .instr    (if_instr),
        .alu_op   (dec_op),
        .use_imm  (use_imm),
        .is_shift (is_shift),
        .legal    (legal)
    );
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign if_ready = reset | ex.ex_ready | ~ex.ex_valid;
    assign xfer     = if_valid & if_ready & ~reset;
    assign imm      = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign op2      = !legal ? '0
                    : is_shift ? {{(XLEN-5){1'b0}}, use_imm ? if_instr[24:20] : rs2_data[4:0]}
                    : use_imm ? imm : rs2_data;
    // ID/EX register: flush beats capture, capture beats hold, an idle ready cycle drains to a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            ex.ex_valid  <= 1'b0;
            ex.alu_op    <= '0;
            ex.data_in_1 <= '0;
            ex.data_in_2 <= '0;
            ex.rd_addr   <= '0;
            ex.reg_write <= 1'b0;
            ex.illegal   <= 1'b0;
        end else if (flush) begin
            ex.ex_valid  <= 1'b0;
            ex.reg_write <= 1'b0;
            ex.illegal   <= 1'b0;
        end else if (xfer) begin
            ex.ex_valid  <= legal | ILL_EN;
            ex.alu_op    <= dec_op;
            ex.data_in_1 <= legal ? rs1_data : '0;
            ex.data_in_2 <= op2;
            ex.rd_addr   <= if_instr[11:7];
            ex.reg_write <= legal & (if_instr[11:7] != 5'd0);
            ex.illegal   <= ILL_EN & ~legal;
        end else if (ex.ex_ready) begin
            ex.ex_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage
module tb_alu_issue_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    int          checks = 0;
    int          errors = 0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif
    alu_issue_stage_if bus ();
    alu_issue_stage dut (
        .clock    (clock),
        .reset    (reset),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .ex       (bus.master)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
        if_valid = v;
        if_instr = instr;
        rs1_data = r1;
        rs2_data = r2;
    endtask
    task automatic check_illegal(input string tag);
        check({tag, "_valid"}, 32'(bus.ex_valid), 32'(ILL_EN));
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(ILL_EN));
        check({tag, "_regwr"}, 32'(bus.reg_write), 32'd0);
        if (ILL_EN) begin
            check({tag, "_op"}, 32'(bus.alu_op), 32'd0);
            check({tag, "_d1"}, bus.data_in_1, 32'd0);
            check({tag, "_d2"}, bus.data_in_2, 32'd0);
        end
    endtask
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        for (int i = 0; i < 2; i++) begin
            tick;
            check("rst_valid", 32'(bus.ex_valid), 32'd0);
            check("rst_op", 32'(bus.alu_op), 32'd0);
            check("rst_d1", bus.data_in_1, 32'd0);
            check("rst_d2", bus.data_in_2, 32'd0);
            check("rst_rd", 32'(bus.rd_addr), 32'd0);
            check("rst_regwr", 32'(bus.reg_write), 32'd0);
            check("rst_illegal", 32'(bus.illegal), 32'd0);
            check("rst_ifready", 32'(if_ready), 32'd1);
        end
        reset = 1'b0;
        if_valid = 1'b0;
        tick;
        check("post_rst_valid", 32'(bus.ex_valid), 32'd0);
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        #1;
        check("add_rs1a", 32'(rs1_addr), 32'd1);
        check("add_rs2a", 32'(rs2_addr), 32'd2);
        tick;
        check("add_valid", 32'(bus.ex_valid), 32'd1);
        check("add_op", 32'(bus.alu_op), 32'd0);
        check("add_d1", bus.data_in_1, 32'd5);
        check("add_d2", bus.data_in_2, 32'd7);
        check("add_rd", 32'(bus.rd_addr), 32'd3);
        check("add_regwr", 32'(bus.reg_write), 32'd1);
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'd0, 32'd0);
        #1;
        check("stall_ifready", 32'(if_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_valid", 32'(bus.ex_valid), 32'd1);
            check("stall_op", 32'(bus.alu_op), 32'd0);
            check("stall_d1", bus.data_in_1, 32'd5);
            check("stall_d2", bus.data_in_2, 32'd7);
            check("stall_rd", 32'(bus.rd_addr), 32'd3);
            check("stall_ifready", 32'(if_ready), 32'd0);
        end
        bus.ex_ready = 1'b1;
        #1;
        check("release_ifready", 32'(if_ready), 32'd1);
        tick;
        check("addi_valid", 32'(bus.ex_valid), 32'd1);
        check("addi_op", 32'(bus.alu_op), 32'd10);
        check("addi_d1", bus.data_in_1, 32'd0);
        check("addi_d2", bus.data_in_2, 32'hFFFFFFFF);
        check("addi_rd", 32'(bus.rd_addr), 32'd1);
        check("addi_regwr", 32'(bus.reg_write), 32'd1);
        drive(1'b1, 32'h40335293, 32'h80000000, 32'd0);
        tick;
        check("srai_op", 32'(bus.alu_op), 32'd16);
        check("srai_d1", bus.data_in_1, 32'h80000000);
        check("srai_d2", bus.data_in_2, 32'd3);
        check("srai_rd", 32'(bus.rd_addr), 32'd5);
        drive(1'b1, 32'h00209233, 32'd1, 32'h00000123);
        tick;
        check("sll_op", 32'(bus.alu_op), 32'd5);
        check("sll_d2", bus.data_in_2, 32'd3);
        check("sll_rd", 32'(bus.rd_addr), 32'd4);
        drive(1'b1, 32'h402081B3, 32'd9, 32'd7);
        tick;
        check("sub_op", 32'(bus.alu_op), 32'd1);
        check("sub_d1", bus.data_in_1, 32'd9);
        check("sub_d2", bus.data_in_2, 32'd7);
        drive(1'b1, 32'hFFF03093, 32'h10, 32'd0);
        tick;
        check("sltiu_op", 32'(bus.alu_op), 32'd18);
        check("sltiu_d2", bus.data_in_2, 32'hFFFFFFFF);
        drive(1'b1, 32'h00208033, 32'd5, 32'd7);
        tick;
        check("rd0_valid", 32'(bus.ex_valid), 32'd1);
        check("rd0_regwr", 32'(bus.reg_write), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'd0, 32'd0);
        tick;
        check("flush_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_regwr", 32'(bus.reg_write), 32'd0);
        flush = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        tick;
        check("after_flush_valid", 32'(bus.ex_valid), 32'd1);
        check("after_flush_op", 32'(bus.alu_op), 32'd0);
        check("after_flush_regwr", 32'(bus.reg_write), 32'd1);
        if_valid = 1'b0;
        tick;
        check("bubble_valid", 32'(bus.ex_valid), 32'd0);
        drive(1'b1, 32'h00000073, 32'd3, 32'd4);
        tick;
        check_illegal("ecall");
        drive(1'b1, 32'h022081B3, 32'd3, 32'd4);
        tick;
        check_illegal("mul");
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        tick;
        check("pre_sflush_valid", 32'(bus.ex_valid), 32'd1);
        bus.ex_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'd0, 32'd0);
        tick;
        check("stall_flush_valid", 32'(bus.ex_valid), 32'd0);
        flush = 1'b0;
        #1;
        check("stall_flush_ifready", 32'(if_ready), 32'd1);
        tick;
        check("refill_valid", 32'(bus.ex_valid), 32'd1);
        check("refill_op", 32'(bus.alu_op), 32'd10);
        reset = 1'b1;
        tick;
        check("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
        check("mid_rst_op", 32'(bus.alu_op), 32'd0);
        check("mid_rst_d2", bus.data_in_2, 32'd0);
        check("mid_rst_rd", 32'(bus.rd_addr), 32'd0);
        check("mid_rst_regwr", 32'(bus.reg_write), 32'd0);
        reset = 1'b0;
        if_valid = 1'b0;
        bus.ex_ready = 1'b1;
        tick;
        check("final_valid", 32'(bus.ex_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue pipeline stage that drives the ALU's input interface. It accepts RV32I instructions from fetch over a valid/ready handshake and reads operands from the register file. It decodes OP and OP-IMM encodings into the 6-bit ALU operation code, builds both operands, and registers them into the ID/EX pipeline register that feeds the ALU's `data_in_1`, `data_in_2` and `alu_op` inputs. Stall and flush control live here.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  32  instruction word.
- `if_ready`  out  1  stage accepts this cycle.
- `rs1_addr`, `rs2_addr`  out  5 each  combinational: `if_instr[19:15]`, `if_instr[24:20]`.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data, same cycle.
- `flush`  in  1  kill the pipeline-register contents.
- `ex_ready`  in  1  ALU/EX stage can take the issued op.
- `ex_valid`  out  1  registered op is valid.
- `alu_op`  out  6  ALU operation code.
- `data_in_1`, `data_in_2`  out  32 each  ALU operands.
- `rd_addr`  out  5  destination register.
- `reg_write`  out  1  writeback enable.
- `illegal`  out  1  unsupported encoding issued.

## Operation
- Opcode map:
  - OP (0110011): ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - SUB and SRA are selected by `funct7=0100000`; every other funct7 on OP is unsupported.
  - OP-IMM (0010011): ADDI 10, XORI 11, ORI 12, ANDI 13, SLLI 14, SRLI 15, SRAI 16, SLTI 17, SLTIU 18.
  - SRAI is selected by `imm[11:5]=0100000`. Shift-immediates with any other `imm[11:5]` (other than 0000000) are unsupported.
- Operand 1 is always `rs1_data`.
- Operand 2:
  - R-type: `rs2_data`.
  - I-type: `imm[11:0]` sign-extended to 32 bits. SLTIU also uses the sign-extended value.
  - Shifts (R and I): the shift amount is zero-extended to 32 bits (`rs2_data[4:0]` or `imm[4:0]`), so the ALU never sees a shift count ≥ 32.
- `reg_write` = 1 for legal ops with `rd != 0`; 0 otherwise.
- Handshake:
  - `if_ready = ex_ready | ~ex_valid` (pure combinational, no skid).
  - A transfer occurs when `if_valid & if_ready`.
  - The register holds its value while `ex_valid & ~ex_ready`.
  - If there is no transfer and `ex_ready=1`, then `ex_valid` goes to 0 next cycle.

## Timing
- Latency: 1 cycle from accepted instruction to `ex_valid`. The ALU adds its own cycle, so the result is visible 2 edges after acceptance.
- Reset values: `ex_valid`, `alu_op`, `data_in_1`, `data_in_2`, `rd_addr`, `reg_write` and `illegal` are all 0. While `reset=1`, `if_ready=1` but nothing is captured.
- Flush:
  - `flush=1` forces `ex_valid=0` and `reg_write=0` next cycle and takes priority over capture and hold.
  - An instruction handshaken in the same cycle is consumed and discarded.
- Stall: when `ex_ready=0`, all outputs stay bit-identical across cycles and fetch is back-pressured.
- Stall release: when `ex_ready` rises while `if_valid=1`, the new instruction is accepted that same edge (back-to-back, no bubble).
- Reset mid-stall: everything clears; the held op is lost.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - An unsupported encoding is issued with `ex_valid=1`, `illegal=1`, `alu_op=0`, both operands 0 and `reg_write=0`.
  - It obeys the same stall/flush rules as any other op.
- Not defined:
  - `illegal` is tied to 0.
  - An unsupported encoding is accepted and dropped: `ex_valid=0` the next cycle, as a bubble.

## Structure
- Package `alu_pkg` holds:
  - `localparam`s `ALU_ADD`…`ALU_SLTIU` (values 0–18), matching the ALU's case table.
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`.
  - `FUNCT7_ALT` (0100000).
- One combinational sub-module, `alu_op_decode`: `instr` → `alu_op`, `use_imm`, `is_shift`, `legal`.
- The top level holds the operand muxes, the pipeline register and the handshake.

## Test plan
- Reset: hold `reset` 2 cycles with `if_valid=1` and `if_instr=0x002081B3` → all outputs 0 during reset; `ex_valid=0` on the first cycle after release.
- `0x002081B3` (add x3,x1,x2) with rs1=5, rs2=7 → next cycle `ex_valid=1`, `alu_op=0`, `data_in_1=5`, `data_in_2=7`, `rd_addr=3`, `reg_write=1`.
- `0xFFF00093` (addi x1,x0,-1) with rs1=0 → `alu_op=10`, `data_in_2=0xFFFFFFFF`, `rd_addr=1`. Then `0x40335293` (srai x5,x6,3) → `alu_op=16`, `data_in_2=3`.
- Stall: `ex_ready=0` for 3 cycles after the add issues, with a new instruction pending → `if_ready=0` and outputs unchanged for 3 cycles. When `ex_ready` rises, the pending instruction is accepted that edge and issued next cycle.
- Flush: `flush=1` in the same cycle a valid addi is handshaken → `ex_valid=0` next cycle; the following instruction issues normally.
- `0x00000073` (ecall):
  - With `ALU_ISSUE_ILLEGAL_EN`: `ex_valid=1`, `illegal=1`, `reg_write=0`.
  - Without it: `ex_valid=0` and `illegal=0`.
